// File: rtl/sirius_pkg.sv
// -----------------------------------------------------------------------------
// sirius_pkg
//   Types and constants shared by the fetch/decode front end.
//   fetch_entry_t : one queued instruction, {addr, inst}
//   RESET_PC      : boot vector, also the base of the address sequences
//                   written to the instruction queue
//   INST_BYTES    : PC step between adjacent fetch slots
//   slot_count()  : 0/1/2 from a (slot 1 valid, slot 2 valid) pair, where
//                   slot 2 only counts when slot 1 is also valid
// -----------------------------------------------------------------------------
package sirius_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [31:0] RESET_PC   = 32'hbfc0_0000;
    localparam logic [31:0] INST_BYTES = 32'd4;

    // Slot 2 is only meaningful together with slot 1; a lone slot-2 strobe
    // counts as nothing.
    function automatic logic [1:0] slot_count(input logic v1, input logic v2);
        return v1 ? (v2 ? 2'd2 : 2'd1) : 2'd0;
    endfunction

endpackage

// File: rtl/inst_fifo_mem.sv
// -----------------------------------------------------------------------------
// inst_fifo_mem
//   DEPTH x fetch_entry_t storage for the instruction queue.
//   Two write ports at adjacent indices (waddr, waddr+1) and two asynchronous
//   read ports at adjacent indices (raddr, raddr+1). Index arithmetic wraps
//   modulo DEPTH. Storage is not reset.
//   Ports:
//     clk              write clock, rising edge
//     we_1 / we_2      write enables for slot 1 (waddr) and slot 2 (waddr+1)
//     waddr            base write index
//     wdata_1/wdata_2  entries written to waddr / waddr+1
//     raddr            base read index
//     rdata_1/rdata_2  entries at raddr / raddr+1 (combinational)
// -----------------------------------------------------------------------------
module inst_fifo_mem
    import sirius_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         we_1,
    input  logic         we_2,
    input  logic [AW-1:0] waddr,
    input  fetch_entry_t wdata_1,
    input  fetch_entry_t wdata_2,
    input  logic [AW-1:0] raddr,
    output fetch_entry_t rdata_1,
    output fetch_entry_t rdata_2
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] waddr_2;
    logic [AW-1:0] raddr_2;

    // DEPTH is a power of two, so AW-bit addition wraps exactly at DEPTH.
    assign waddr_2 = waddr + AW'(1);
    assign raddr_2 = raddr + AW'(1);

    // The two write indices are always distinct, so both writes can land in
    // the same cycle without a priority question.
    always_ff @(posedge clk) begin
        if (we_1) mem[waddr]   <= wdata_1;
        if (we_2) mem[waddr_2] <= wdata_2;
    end

    assign rdata_1 = mem[raddr];
    assign rdata_2 = mem[raddr_2];

endmodule

// File: rtl/inst_fifo.sv
// -----------------------------------------------------------------------------
// inst_fifo
//   Dual-write / dual-read instruction queue between fetch and decode/issue.
//   Accepts 0-2 fetched instructions per cycle, presents the two oldest
//   entries fall-through to the dual-issue decoder, raises fifo_full early
//   enough to absorb fetches already in flight, and empties on flush.
//   Ports:
//     clk, rst                  clock; asynchronous active-low reset
//     flush                     discard all entries (redirect)
//     inst_ok_1/inst_ok_2       fetch slot valids (slot 2 only with slot 1)
//     inst_addr_1               PC of slot 1; slot 2 PC is inst_addr_1 + 4
//     inst_data_1/inst_data_2   fetched instruction words
//     fifo_full                 fetch hold to the PC stage
//     out_valid/addr/inst_1,2   head and head+1 entries (zero when invalid)
//     deq_1/deq_2               decoder consumes head / also head+1
//     count                     occupied entries
//     overflow                  sticky: a write was dropped for lack of space
// -----------------------------------------------------------------------------
module inst_fifo
    import sirius_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int FULL_SLACK = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     inst_ok_1,
    input  logic                     inst_ok_2,
    input  logic [31:0]              inst_addr_1,
    input  logic [31:0]              inst_data_1,
    input  logic [31:0]              inst_data_2,
    output logic                     fifo_full,
    output logic                     out_valid_1,
    output logic [31:0]              out_addr_1,
    output logic [31:0]              out_inst_1,
    output logic                     out_valid_2,
    output logic [31:0]              out_addr_2,
    output logic [31:0]              out_inst_2,
    input  logic                     deq_1,
    input  logic                     deq_2,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // One extra bit so DEPTH - count + n_rd can be formed without wrapping.
    localparam int FW = CW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          ovf_q;

    logic [1:0]    n_wr;
    logic [1:0]    n_rd_req;
    logic [1:0]    n_rd;
    logic [1:0]    n_acc;
    logic [FW-1:0] free;
    logic          drop;
    logic          we_1;
    logic          we_2;

    fetch_entry_t  wdata_1;
    fetch_entry_t  wdata_2;
    fetch_entry_t  rdata_1;
    fetch_entry_t  rdata_2;

    // ------------------------------------------------------------------
    // Write / read accounting
    // ------------------------------------------------------------------
    always_comb begin
        n_wr     = slot_count(inst_ok_1, inst_ok_2);
        n_rd_req = slot_count(deq_1, deq_2);

        // Dequeue beyond what is held is clipped; only cnt of 0 or 1 can
        // be smaller than a request, so the low two bits are exact there.
        n_rd = n_rd_req;
        if (CW'(n_rd_req) > cnt) n_rd = cnt[1:0];

        // Entries leaving this cycle free their slots for this cycle's writes.
        free = FW'(DEPTH) - FW'(cnt) + FW'(n_rd);

        // Slot 1 takes priority; anything that does not fit is dropped.
        n_acc = n_wr;
        drop  = 1'b0;
        if (FW'(n_wr) > free) begin
            n_acc = free[1:0];
            drop  = 1'b1;
        end

        we_1 = !flush && (n_acc != 2'd0);
        we_2 = !flush && (n_acc == 2'd2);
    end

    assign wdata_1 = '{addr: inst_addr_1,              inst: inst_data_1};
    assign wdata_2 = '{addr: inst_addr_1 + INST_BYTES, inst: inst_data_2};

    // ------------------------------------------------------------------
    // Pointers, occupancy, sticky overflow
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
        end else if (flush) begin
            // Redirect wins over same-cycle traffic; overflow history is kept.
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(n_acc);
            rd_ptr <= rd_ptr + AW'(n_rd);
            cnt    <= cnt + CW'(n_acc) - CW'(n_rd);
            if (drop) ovf_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    inst_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_1    (we_1),
        .we_2    (we_2),
        .waddr   (wr_ptr),
        .wdata_1 (wdata_1),
        .wdata_2 (wdata_2),
        .raddr   (rd_ptr),
        .rdata_1 (rdata_1),
        .rdata_2 (rdata_2)
    );

    // ------------------------------------------------------------------
    // Outputs: fall-through from registered state only, so a write becomes
    // visible the cycle after it is accepted.
    // ------------------------------------------------------------------
    assign count       = cnt;
    assign overflow    = ovf_q;
    assign fifo_full   = cnt > CW'(DEPTH - FULL_SLACK);

    assign out_valid_1 = cnt != '0;
    assign out_valid_2 = cnt >= CW'(2);

    // Invalid slots read as zero so stale storage never reaches decode.
    assign out_addr_1  = out_valid_1 ? rdata_1.addr : 32'd0;
    assign out_inst_1  = out_valid_1 ? rdata_1.inst : 32'd0;
    assign out_addr_2  = out_valid_2 ? rdata_2.addr : 32'd0;
    assign out_inst_2  = out_valid_2 ? rdata_2.inst : 32'd0;

endmodule

// File: tb/tb_inst_fifo.sv
// -----------------------------------------------------------------------------
// tb_inst_fifo
//   Scoreboard bench for inst_fifo. The reference model is a plain queue of
//   {addr, inst}; every cycle the monitor compares the presented outputs with
//   the queue, then applies that cycle's inputs to the queue.
// -----------------------------------------------------------------------------
module tb_inst_fifo;
    import sirius_pkg::*;

    localparam int DEPTH      = 16;
    localparam int FULL_SLACK = 4;

    logic        clk = 1'b0;
    logic        clk_en = 1'b1;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        inst_ok_1 = 1'b0;
    logic        inst_ok_2 = 1'b0;
    logic [31:0] inst_addr_1 = '0;
    logic [31:0] inst_data_1 = '0;
    logic [31:0] inst_data_2 = '0;
    logic        deq_1 = 1'b0;
    logic        deq_2 = 1'b0;
    logic        fifo_full;
    logic        out_valid_1;
    logic [31:0] out_addr_1;
    logic [31:0] out_inst_1;
    logic        out_valid_2;
    logic [31:0] out_addr_2;
    logic [31:0] out_inst_2;
    logic [$clog2(DEPTH):0] count;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    fetch_entry_t q[$];
    logic         ovf_m = 1'b0;
    logic [31:0]  pc;

    inst_fifo #(.DEPTH(DEPTH), .FULL_SLACK(FULL_SLACK)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .inst_ok_1   (inst_ok_1),
        .inst_ok_2   (inst_ok_2),
        .inst_addr_1 (inst_addr_1),
        .inst_data_1 (inst_data_1),
        .inst_data_2 (inst_data_2),
        .fifo_full   (fifo_full),
        .out_valid_1 (out_valid_1),
        .out_addr_1  (out_addr_1),
        .out_inst_1  (out_inst_1),
        .out_valid_2 (out_valid_2),
        .out_addr_2  (out_addr_2),
        .out_inst_2  (out_inst_2),
        .deq_1       (deq_1),
        .deq_2       (deq_2),
        .count       (count),
        .overflow    (overflow)
    );

    // Gateable clock so the async reset can be exercised with no edges.
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard: samples 1 time unit before each rising edge.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        int nr;
        int nw;
        int fr;
        #4;
        if (!rst) begin
            q.delete();
            ovf_m = 1'b0;
        end
        chk("count",     32'(count),       32'(q.size()));
        chk("fifo_full", 32'(fifo_full),   32'(q.size() > DEPTH - FULL_SLACK));
        chk("overflow",  32'(overflow),    32'(ovf_m));
        chk("valid1",    32'(out_valid_1), 32'(q.size() >= 1));
        chk("valid2",    32'(out_valid_2), 32'(q.size() >= 2));
        chk("addr1",     out_addr_1, q.size() >= 1 ? q[0].addr : 32'd0);
        chk("inst1",     out_inst_1, q.size() >= 1 ? q[0].inst : 32'd0);
        chk("addr2",     out_addr_2, q.size() >= 2 ? q[1].addr : 32'd0);
        chk("inst2",     out_inst_2, q.size() >= 2 ? q[1].inst : 32'd0);
        if (rst) begin
            if (flush) begin
                q.delete();
            end else begin
                nr = deq_1 ? (deq_2 ? 2 : 1) : 0;
                if (nr > q.size()) nr = q.size();
                repeat (nr) void'(q.pop_front());
                fr = DEPTH - q.size();
                nw = inst_ok_1 ? (inst_ok_2 ? 2 : 1) : 0;
                if (nw >= 1 && fr >= 1) q.push_back(fetch_entry_t'{addr: inst_addr_1, inst: inst_data_1});
                if (nw == 2 && fr >= 2) q.push_back(fetch_entry_t'{addr: inst_addr_1 + 32'd4, inst: inst_data_2});
                if (nw > fr) ovf_m = 1'b1;
            end
        end
    end

    // One cycle of stimulus: inputs set after the falling edge, return just
    // after the following rising edge so callers see its effect.
    task automatic drive(input logic o1, input logic o2, input logic [31:0] a,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic q1, input logic q2, input logic fl);
        @(negedge clk);
        #1;
        inst_ok_1   = o1;
        inst_ok_2   = o2;
        inst_addr_1 = a;
        inst_data_1 = d1;
        inst_data_2 = d2;
        deq_1       = q1;
        deq_2       = q2;
        flush       = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic put(input int n, input logic q1, input logic q2, input logic fl);
        drive(n >= 1, n == 2, pc, $urandom, $urandom, q1, q2, fl);
        if (!fl) pc = pc + 32'(4 * n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        pc = RESET_PC;
        // 1. reset then idle (monitor checks reset values)
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        idle();
        chk("t1_count", 32'(count), 32'd0);
        chk("t1_valid1", 32'(out_valid_1), 32'd0);

        // 2. first pair becomes visible the following cycle
        drive(1'b1, 1'b1, RESET_PC, 32'h2401_0001, 32'h2402_0002, 1'b0, 1'b0, 1'b0);
        chk("t2_count", 32'(count), 32'd2);
        chk("t2_addr1", out_addr_1, 32'hbfc0_0000);
        chk("t2_addr2", out_addr_2, 32'hbfc0_0004);
        chk("t2_inst2", out_inst_2, 32'h2402_0002);
        pc = RESET_PC + 32'd8;

        // 3. fill: fifo_full above DEPTH-FULL_SLACK, then overflow on a pair too many
        for (int i = 0; i < 7; i++) begin
            chk("t3_count", 32'(count), 32'(2 + 2 * i));
            chk("t3_full", 32'(fifo_full), 32'((2 + 2 * i) > 12));
            put(2, 1'b0, 1'b0, 1'b0);
        end
        chk("t3_count16", 32'(count), 32'd16);
        chk("t3_ovf0", 32'(overflow), 32'd0);
        put(2, 1'b0, 1'b0, 1'b0);
        chk("t3_ovf1", 32'(overflow), 32'd1);
        chk("t3_count_hold", 32'(count), 32'd16);

        // 4. wrap: steady 3 entries, 2 in / 2 out per cycle
        drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        pc = RESET_PC;
        repeat (3) put(1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            put(2, 1'b1, 1'b1, 1'b0);
            chk("t4_count", 32'(count), 32'd3);
        end

        // 5. flush beats same-cycle write and dequeue
        drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        put(2, 1'b0, 1'b0, 1'b0);
        put(1, 1'b0, 1'b0, 1'b0);
        put(2, 1'b0, 1'b0, 1'b0);
        chk("t5_count5", 32'(count), 32'd5);
        put(1, 1'b1, 1'b0, 1'b1);
        chk("t5_count0", 32'(count), 32'd0);
        chk("t5_valid1", 32'(out_valid_1), 32'd0);
        pc = 32'hbfc0_0380;
        put(2, 1'b0, 1'b0, 1'b0);
        chk("t5_head", out_addr_1, 32'hbfc0_0380);
        chk("t5_head2", out_addr_2, 32'hbfc0_0384);

        // 6. lone slot-2 strobes do nothing
        put(1, 1'b0, 1'b0, 1'b0);
        chk("t6_count3", 32'(count), 32'd3);
        drive(1'b0, 1'b1, pc, 32'h1234_5678, 32'h9abc_def0, 1'b0, 1'b0, 1'b0);
        chk("t6_ok2_only", 32'(count), 32'd3);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        chk("t6_deq2_only", 32'(count), 32'd3);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            int n;
            logic q1, q2, fl;
            n  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 2);
            q1 = $urandom_range(0, 3) != 0;
            q2 = $urandom_range(0, 1) != 0;
            fl = $urandom_range(0, 39) == 0;
            if ($urandom_range(0, 9) == 0)
                drive(1'b0, 1'b1, pc, $urandom, $urandom, q1, q2, fl);
            else
                put(n, q1, q2, fl);
        end

        // async reset pulse with the clock stopped
        put(2, 1'b0, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        #1 clk_en = 1'b0;
        #10 rst = 1'b0;
        #1;
        q.delete();
        ovf_m = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid1", 32'(out_valid_1), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        #5 rst = 1'b1;
        #5 clk_en = 1'b1;
        pc = RESET_PC;
        put(2, 1'b0, 1'b0, 1'b0);
        chk("post_rst_head", out_addr_1, RESET_PC);
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
